// File: rtl/ts_pkg.sv
// Shared definitions for the Mic4 temperature-sensor measurement sequencer.
//   ts_state_e      one-hot FSM encoding (6 states)
//   TMO_CYCLES_DEF  default trigger-to-valid timeout (10 ms at 100 MHz)
//   RST_CYCLES_DEF  default number of cycles the sensor reset is held
//   acc_width()     accumulator width: sample width plus log2(samples) guard bits
package ts_pkg;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_TRIG    = 6'b000010,
    S_WAIT    = 6'b000100,
    S_GAP     = 6'b001000,
    S_DONE    = 6'b010000,
    S_RECOVER = 6'b100000
  } ts_state_e;

  localparam int TMO_CYCLES_DEF = 1_000_000;
  localparam int RST_CYCLES_DEF = 4;

  // Summing 2**avg_log2 values of count_width bits needs avg_log2 extra bits.
  function automatic int acc_width(input int count_width, input int avg_log2);
    return count_width + avg_log2;
  endfunction

endpackage

// File: rtl/ts_seq_timer.sv
// Loadable down-counter shared by the sequencer for the WAIT timeout, the GAP
// interval and the RECOVER reset hold.
//   clk, rst_n   clock, asynchronous active-low reset
//   i_load       load i_load_val this cycle (wins over counting)
//   i_load_val   value to load
//   o_zero       counter currently holds 0
// The counter decrements once per cycle and saturates at 0, so a value V
// loaded on entry to a state gives V+1 cycles in that state before exit.
module ts_seq_timer #(
  parameter int TMO_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [TMO_WIDTH-1:0] i_load_val,
  output logic                 o_zero
);

  logic [TMO_WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - TMO_WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/ts_meas_sequencer.sv
// Mic4 temperature-sensor sequencer: triggers the sensor, averages
// 2**AVG_LOG2 pulse-length samples and hands the average to the host.
// Ports:
//   clk_100MHz, RESET_N   control clock, asynchronous active-low reset
//   start                 one-shot batch request (sampled in IDLE)
//   continuous            keep restarting batches after each result
//   abort                 cancel batch, reset sensor, return to IDLE
//   interval              idle cycles between samples
//   ts_pulse / ts_rst     sensor trigger (1-cycle) and active-high reset
//   ts_pulse_len/ts_valid sensor sample and its 1-cycle strobe
//   result/result_valid   averaged pulse length and sticky valid
//   result_ack            host consumed result
//   busy, timeout_err     not-IDLE flag, sticky silent-sensor flag
//   dbg_state             current FSM state for observation
// Result handshake: result_valid rises when a batch completes and stays high
// until result_ack is seen; a completion in the same cycle as result_ack
// keeps result_valid high with the new result, and result_ack while
// result_valid is low has no effect.
module ts_meas_sequencer
  import ts_pkg::*;
#(
  parameter int TS_COUNT_WIDTH = 32,
  parameter int AVG_LOG2       = 3,
  parameter int TMO_WIDTH      = 24,
  parameter int TMO_CYCLES     = TMO_CYCLES_DEF,
  parameter int RST_CYCLES     = RST_CYCLES_DEF
) (
  input  logic                      clk_100MHz,
  input  logic                      RESET_N,
  input  logic                      start,
  input  logic                      continuous,
  input  logic                      abort,
  input  logic [TMO_WIDTH-1:0]      interval,
  output logic                      ts_pulse,
  output logic                      ts_rst,
  input  logic [TS_COUNT_WIDTH-1:0] ts_pulse_len,
  input  logic                      ts_valid,
  output logic [TS_COUNT_WIDTH-1:0] result,
  output logic                      result_valid,
  input  logic                      result_ack,
  output logic                      busy,
  output logic                      timeout_err,
  output ts_state_e                 dbg_state
);

  localparam int ACC_W = acc_width(TS_COUNT_WIDTH, AVG_LOG2);
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  ts_state_e                 r_state;
  logic [ACC_W-1:0]          r_acc;
  logic [CNT_W-1:0]          r_cnt;
  logic [TS_COUNT_WIDTH-1:0] r_result;
  logic                      r_result_valid;
  logic                      r_timeout_err;

  logic                      w_abort;
  logic                      w_sample;
  logic                      w_last;
  logic                      w_timeout;
  logic                      w_tmr_zero;
  logic                      w_tmr_load;
  logic [TMO_WIDTH-1:0]      w_tmr_val;
  logic [ACC_W-1:0]          w_len_ext;

  // Abort only acts while a batch is in flight; RECOVER already resets the sensor.
  assign w_abort   = abort && (r_state != S_IDLE) && (r_state != S_RECOVER);
  // Abort wins over a sample arriving in the same cycle.
  assign w_sample  = (r_state == S_WAIT) && ts_valid && !w_abort;
  assign w_last    = w_sample && (r_cnt == LAST_CNT);
  // A sample on the final timer cycle still counts; timeout needs silence.
  assign w_timeout = (r_state == S_WAIT) && !ts_valid && w_tmr_zero && !w_abort;
  assign w_len_ext = ACC_W'(ts_pulse_len);

  // Timer loads happen on the transition into the state that uses them.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    if (w_abort || w_timeout) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = TMO_WIDTH'(RST_CYCLES - 1);
    end else if (r_state == S_TRIG) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = TMO_WIDTH'(TMO_CYCLES - 1);
    end else if (w_sample && !w_last) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = interval;
    end
  end

  ts_seq_timer #(
    .TMO_WIDTH (TMO_WIDTH)
  ) u_timer (
    .clk        (clk_100MHz),
    .rst_n      (RESET_N),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_cnt          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      // Overridden below when a batch completes in this same cycle.
      if (result_ack) begin
        r_result_valid <= 1'b0;
      end
      if (w_abort) begin
        r_state <= S_RECOVER;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start || continuous) begin
              r_state <= S_TRIG;
              r_acc   <= '0;
              r_cnt   <= '0;
              if (start) begin
                r_timeout_err <= 1'b0;
              end
            end
          end
          S_TRIG: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (w_sample) begin
              r_acc   <= r_acc + w_len_ext;
              r_cnt   <= r_cnt + CNT_W'(1);
              r_state <= w_last ? S_DONE : S_GAP;
            end else if (w_timeout) begin
              r_timeout_err <= 1'b1;
              r_state       <= S_RECOVER;
              r_acc         <= '0;
              r_cnt         <= '0;
            end
          end
          S_GAP: begin
            if (w_tmr_zero) begin
              r_state <= S_TRIG;
            end
          end
          S_DONE: begin
            r_result       <= TS_COUNT_WIDTH'(r_acc >> AVG_LOG2);
            r_result_valid <= 1'b1;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_state        <= continuous ? S_TRIG : S_IDLE;
          end
          S_RECOVER: begin
            if (w_tmr_zero) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // One-hot state bits are flops, so these decodes are glitch-free.
  assign ts_pulse     = (r_state == S_TRIG);
  assign ts_rst       = (r_state == S_RECOVER);
  assign busy         = (r_state != S_IDLE);
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign timeout_err  = r_timeout_err;
  assign dbg_state    = r_state;

endmodule
